// File: rtl/lut_config_loader.sv
// ---------------------------------------------------------------------------
// lut_config_loader
//
// Configuration sequencer for a column of shift-loaded LUs. A serial
// bitstream arrives over a valid/ready handshake. Each accepted bit is placed
// on the shared config_data_in line together with a one-cycle strobe to
// exactly one LU. LU 0 is loaded first. The first bit for an LU ends up in
// its q0. When every LU has received LUT_BITS strobes, the loader releases
// prgm_b and all CLB_prgm_b lines, which puts the fabric in operate mode.
//
// Parameters
//   NUM_LUT   number of LUs in the chain (1..64)
//   LUT_BITS  bits per LU (sets the width of the bit counter only)
//
// Ports
//   clk             single clock, rising edge
//   reset           asynchronous, active-low
//   start           one-cycle pulse; begins a pass from IDLE or DONE
//   cfg_valid       source presents a bit on cfg_bit
//   cfg_bit         serial configuration bit
//   cfg_ready       loader accepts a bit this cycle (high only in LOAD)
//   config_data_in  shared data line to all LUs (registered)
//   CLB_prgm_b_in   one-hot per-LU shift strobe, one cycle per transfer
//   CLB_prgm_b_out  per-LU "loaded" flag, sticky until the next start
//   CLB_prgm_b      per-LU operate enable, active-low
//   prgm_b          global mode: 0 = programming, 1 = operate
//   busy            high from start acceptance until DONE is entered
//   done            high while in DONE
// ---------------------------------------------------------------------------
module lut_config_loader #(
    parameter int NUM_LUT  = 4,
    parameter int LUT_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_valid,
    input  logic               cfg_bit,
    output logic               cfg_ready,
    output logic               config_data_in,
    output logic [NUM_LUT-1:0] CLB_prgm_b_in,
    output logic [NUM_LUT-1:0] CLB_prgm_b_out,
    output logic [NUM_LUT-1:0] CLB_prgm_b,
    output logic               prgm_b,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (NUM_LUT  > 1) ? $clog2(NUM_LUT)  : 1;
    localparam int CNT_W = (LUT_BITS > 1) ? $clog2(LUT_BITS) : 1;

    localparam logic [IDX_W-1:0] LAST_LUT = IDX_W'(NUM_LUT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LUT_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MARK,
        S_FINISH,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] lut_idx;
    logic [CNT_W-1:0] bit_cnt;

    // All outputs are registered. cfg_ready is set on entry to LOAD and
    // cleared on the edge that leaves it, so cfg_ready is high exactly while
    // in LOAD.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            lut_idx        <= '0;
            bit_cnt        <= '0;
            cfg_ready      <= 1'b0;
            config_data_in <= 1'b0;
            CLB_prgm_b_in  <= '0;
            CLB_prgm_b_out <= '0;
            CLB_prgm_b     <= '1;
            prgm_b         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            // NOTE: the strobe defaults to zero every cycle. Only an accepted
            // transfer raises it, so a stall never shifts an LU and a strobe
            // never lasts more than one cycle.
            CLB_prgm_b_in <= '0;

            case (state)
                // IDLE and DONE share the start path. From DONE this is a
                // reconfiguration: the fabric drops back to programming mode
                // on the edge that accepts start.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_LOAD;
                        lut_idx        <= '0;
                        bit_cnt        <= '0;
                        CLB_prgm_b_out <= '0;
                        CLB_prgm_b     <= '1;
                        prgm_b         <= 1'b0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        cfg_ready      <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        config_data_in <= cfg_bit;
                        CLB_prgm_b_in  <= NUM_LUT'(1) << lut_idx;
                        bit_cnt        <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            cfg_ready <= 1'b0;
                            state     <= S_SETTLE;
                        end
                    end
                end

                // The last strobe for this LU is on the wire during this
                // cycle. The default above clears it at the end of the cycle.
                S_SETTLE: begin
                    state <= S_MARK;
                end

                // The loaded flag rises only after the strobe is already low,
                // so the LU never sees both lines high together.
                S_MARK: begin
                    CLB_prgm_b_out[lut_idx] <= 1'b1;
                    if (lut_idx == LAST_LUT) begin
                        state <= S_FINISH;
                    end else begin
                        lut_idx   <= lut_idx + IDX_W'(1);
                        bit_cnt   <= '0;
                        cfg_ready <= 1'b1;
                        state     <= S_LOAD;
                    end
                end

                S_FINISH: begin
                    CLB_prgm_b <= '0;
                    prgm_b     <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// ---------------------------------------------------------------------------
// tb_lut_config_loader
//
// Self-checking bench for lut_config_loader (NUM_LUT = 4, LUT_BITS = 16).
// A monitor on the falling edge models the LU column as plain shift registers
// (first bit shifted in ends in q0) and derives the expected strobe from the
// count of accepted transfers: transfer n goes to LU n/16. The expected LU
// contents are simply the patterns that were streamed in.
// ---------------------------------------------------------------------------
module tb_lut_config_loader;

    localparam int N = 4;
    localparam int B = 16;
    localparam int PASS_CYCLES = 1 + 18 * N + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_bit = 1'b0;
    logic         cfg_ready;
    logic         config_data_in;
    logic [N-1:0] CLB_prgm_b_in;
    logic [N-1:0] CLB_prgm_b_out;
    logic [N-1:0] CLB_prgm_b;
    logic         prgm_b;
    logic         busy;
    logic         done;

    lut_config_loader #(.NUM_LUT(N), .LUT_BITS(B)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_valid      (cfg_valid),
        .cfg_bit        (cfg_bit),
        .cfg_ready      (cfg_ready),
        .config_data_in (config_data_in),
        .CLB_prgm_b_in  (CLB_prgm_b_in),
        .CLB_prgm_b_out (CLB_prgm_b_out),
        .CLB_prgm_b     (CLB_prgm_b),
        .prgm_b         (prgm_b),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- LU column model and strobe expectation ----------------
    logic [15:0]  lut_model [N];
    int           strobe_cnt [N];
    int           xfer_count = 0;
    logic         prev_xfer = 1'b0;
    logic         prev_bit = 1'b0;
    logic [N-1:0] prev_exp_strobe = '0;

    initial for (int i = 0; i < N; i++) begin
        lut_model[i]  = '0;
        strobe_cnt[i] = 0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            prev_xfer       = 1'b0;
            prev_exp_strobe = '0;
            xfer_count      = 0;
        end else begin
            check("strobe", 32'(CLB_prgm_b_in), 32'(prev_exp_strobe));
            if (prev_xfer) check("data_line", 32'(config_data_in), 32'(prev_bit));
            for (int i = 0; i < N; i++) begin
                if (CLB_prgm_b_in[i]) begin
                    lut_model[i] = {config_data_in, lut_model[i][15:1]};
                    strobe_cnt[i]++;
                end
            end
            // start is honoured only in IDLE (nothing sent yet) or DONE (all sent)
            if (start && (xfer_count == 0 || xfer_count == N * B)) begin
                xfer_count = 0;
                for (int i = 0; i < N; i++) strobe_cnt[i] = 0;
            end
            prev_xfer = cfg_valid && cfg_ready;
            prev_bit  = cfg_bit;
            prev_exp_strobe = prev_xfer ? (N'(1) << (xfer_count / B)) : '0;
            if (prev_xfer) xfer_count++;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int c0);
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic send_stream(input logic [15:0] pats [N], input int num_bits,
                               input int idle_pct, input int start_k);
        for (int k = 0; k < num_bits; k++) begin
            logic acc;
            int   t;
            while ($urandom_range(99, 0) < idle_pct) tick();
            cfg_bit   = pats[k / B][k % B];
            cfg_valid = 1'b1;
            start     = (k == start_k);
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = cfg_ready;
                tick();
                start = 1'b0;
                t++;
            end
            cfg_valid = 1'b0;
            if (!acc) check("handshake_timeout", 32'd0, 32'd1);
            else      check("busy_during_load", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_done(input int c0, output int elapsed);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
        elapsed = cyc - c0 + 1;
    endtask

    task automatic check_finished(input logic [15:0] pats [N], input logic per_addr);
        check("done",           32'(done),           32'd1);
        check("busy_at_done",   32'(busy),           32'd0);
        check("prgm_b_operate", 32'(prgm_b),         32'd1);
        check("clb_prgm_b_low", 32'(CLB_prgm_b),     32'd0);
        check("loaded_flags",   32'(CLB_prgm_b_out), 32'(N'('1)));
        for (int i = 0; i < N; i++) begin
            check("lut_word", 32'(lut_model[i]), 32'(pats[i]));
            check("strobe_count", 32'(strobe_cnt[i]), 32'(B));
            if (per_addr)
                for (int a = 0; a < B; a++)
                    check("lut_addr", 32'(lut_model[i][a]), 32'(pats[i][a]));
        end
    endtask

    // ---------------- directed vectors just after reset ----------------
    typedef struct {
        logic         st;
        logic         valid;
        logic         bitv;
        logic         ready;
        logic         bsy;
        logic [N-1:0] strobe;
        logic         data;
        logic         prgm;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] pats_a [N];
        logic [15:0] pats_f [N];
        logic [16:0] snap;
        int c0, elapsed;

        //            st    valid bit   ready bsy   strobe   data  prgm
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0}; // valid ignored in IDLE
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0}; // start accepted, no transfer yet
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0}; // first transfer
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0}; // stall: data held
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0}; // start in LOAD ignored
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};

        for (int i = 0; i < N; i++) begin
            pats_a[i] = 16'hA5C3 + 16'(i);
            pats_f[i] = 16'h0F0F;
        end

        // ---- reset and idle ----
        #23;
        check("rst_prgm_b",     32'(prgm_b),     32'd0);
        check("rst_clb_prgm_b", 32'(CLB_prgm_b), 32'hF);
        check("rst_cfg_ready",  32'(cfg_ready),  32'd0);
        check("rst_done",       32'(done),       32'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            snap = {cfg_ready, prgm_b, done, busy, config_data_in,
                    CLB_prgm_b_in, CLB_prgm_b_out, CLB_prgm_b};
            check("idle_hold", 32'(snap), 32'h0000F);
        end

        // ---- directed vector table ----
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].st; cfg_valid = vecs[i].valid; cfg_bit = vecs[i].bitv;
            tick();
            check("vec_ready",  32'(cfg_ready),      32'(vecs[i].ready));
            check("vec_busy",   32'(busy),           32'(vecs[i].bsy));
            check("vec_strobe", 32'(CLB_prgm_b_in),  32'(vecs[i].strobe));
            check("vec_data",   32'(config_data_in), 32'(vecs[i].data));
            check("vec_prgm_b", 32'(prgm_b),         32'(vecs[i].prgm));
        end
        start = 1'b0; cfg_valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ---- back-to-back pass ----
        pulse_start(c0);
        send_stream(pats_a, N * B, 0, -1);
        wait_done(c0, elapsed);
        check("pass_latency", 32'(elapsed), 32'(PASS_CYCLES));
        check_finished(pats_a, 1'b1);

        // ---- random cfg_valid gaps ----
        pulse_start(c0);
        send_stream(pats_a, N * B, 40, -1);
        wait_done(c0, elapsed);
        check_finished(pats_a, 1'b0);

        // ---- start pulsed at bit 7 of LU 1: ignored ----
        pulse_start(c0);
        send_stream(pats_a, N * B, 0, B + 7);
        wait_done(c0, elapsed);
        check("ignored_start_latency", 32'(elapsed), 32'(PASS_CYCLES));
        check_finished(pats_a, 1'b0);

        // ---- reset at bit 10 of LU 2, then full reload ----
        pulse_start(c0);
        send_stream(pats_a, 2 * B + 10, 0, -1);
        check("pre_rst_strobe", 32'(CLB_prgm_b_in),  32'h4);
        check("pre_rst_flags",  32'(CLB_prgm_b_out), 32'h3);
        #2 reset = 1'b0;
        #1;
        check("arst_strobe",     32'(CLB_prgm_b_in),  32'd0);
        check("arst_flags",      32'(CLB_prgm_b_out), 32'd0);
        check("arst_ready",      32'(cfg_ready),      32'd0);
        check("arst_busy",       32'(busy),           32'd0);
        check("arst_clb_prgm_b", 32'(CLB_prgm_b),     32'hF);
        check("arst_data",       32'(config_data_in), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        pulse_start(c0);
        send_stream(pats_a, N * B, 0, -1);
        wait_done(c0, elapsed);
        check_finished(pats_a, 1'b0);

        // ---- reconfiguration from DONE with a new pattern ----
        check("done_prgm_b", 32'(prgm_b), 32'd1);
        pulse_start(c0);
        check("reconf_prgm_b",     32'(prgm_b),         32'd0);
        check("reconf_flags",      32'(CLB_prgm_b_out), 32'd0);
        check("reconf_clb_prgm_b", 32'(CLB_prgm_b),     32'hF);
        check("reconf_done",       32'(done),           32'd0);
        send_stream(pats_f, N * B, 0, -1);
        wait_done(c0, elapsed);
        check("reconf_latency", 32'(elapsed), 32'(PASS_CYCLES));
        check_finished(pats_f, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
